// File: rtl/term_char_writer.sv
// term_char_writer: character-entry controller for the Apple-1 video terminal.
// Takes 7-bit ASCII from the PIA using a DA/RDA handshake and tracks the 40x24
// cursor. For each printable character it issues a one-cycle write strobe,
// with the character code and cursor address, to the screen-memory write
// logic. When the cursor runs past the last row it requests a one-line
// scroll and waits for the acknowledge before accepting the next character.
module term_char_writer #(
    parameter int         COLS    = 40,
    parameter int         ROWS    = 24,
    parameter logic [6:0] CR_CODE = 7'h0D
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dav,
    input  logic [6:0] data,
    input  logic       clr,
    input  logic       scroll_ack,
    output logic       rda,
    output logic       char_we,
    output logic [5:0] char_out,
    output logic [5:0] wr_col,
    output logic [4:0] wr_row,
    output logic       scroll_req
);

    localparam logic [5:0] COL_LAST = 6'(COLS - 1);
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ADVANCE,
        ST_NEWLINE,
        ST_SCROLL,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [6:0] char_reg_q, char_reg_d;
    logic       dav_hist_q, dav_hist_d;
    logic       rda_q, rda_d;
    logic       char_we_q, char_we_d;
    logic [5:0] char_out_q, char_out_d;
    logic [5:0] wr_col_q, wr_col_d;
    logic [4:0] wr_row_q, wr_row_d;
    logic       scroll_req_q, scroll_req_d;

    logic       trigger;
    logic       printable;

    // Rising edge of dav starts a character; history resets high so a dav
    // already asserted when reset is released is not taken as new data.
    assign trigger   = dav & ~dav_hist_q;
    assign printable = (char_reg_q >= 7'h20) && (char_reg_q <= 7'h5F);

    // Next-state and registered-output logic; clr overrides every state.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        char_reg_d   = char_reg_q;
        dav_hist_d   = dav;
        rda_d        = rda_q;
        char_we_d    = 1'b0;
        char_out_d   = char_out_q;
        wr_col_d     = wr_col_q;
        wr_row_d     = wr_row_q;
        scroll_req_d = scroll_req_q;

        if (clr) begin
            state_d      = ST_IDLE;
            col_d        = 6'd0;
            row_d        = 5'd0;
            rda_d        = 1'b1;
            scroll_req_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        char_reg_d = data;
                        rda_d      = 1'b0;
                        state_d    = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (printable) begin
                        char_we_d  = 1'b1;
                        char_out_d = char_reg_q[5:0];
                        wr_col_d   = col_q;
                        wr_row_d   = row_q;
                        state_d    = ST_ADVANCE;
                    end else if (char_reg_q == CR_CODE) begin
                        state_d = ST_NEWLINE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_ADVANCE: begin
                    if (col_q == COL_LAST) begin
                        col_d   = 6'd0;
                        state_d = ST_NEWLINE;
                    end else begin
                        col_d   = col_q + 6'd1;
                        state_d = ST_DONE;
                    end
                end
                ST_NEWLINE: begin
                    col_d = 6'd0;
                    if (row_q < ROW_LAST) begin
                        row_d   = row_q + 5'd1;
                        state_d = ST_DONE;
                    end else begin
                        scroll_req_d = 1'b1;
                        state_d      = ST_SCROLL;
                    end
                end
                ST_SCROLL: begin
                    if (scroll_ack) begin
                        scroll_req_d = 1'b0;
                        state_d      = ST_DONE;
                    end
                end
                ST_DONE: begin
                    rda_d   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    rda_d   = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            col_q        <= 6'd0;
            row_q        <= 5'd0;
            char_reg_q   <= 7'd0;
            dav_hist_q   <= 1'b1;
            rda_q        <= 1'b1;
            char_we_q    <= 1'b0;
            char_out_q   <= 6'd0;
            wr_col_q     <= 6'd0;
            wr_row_q     <= 5'd0;
            scroll_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            char_reg_q   <= char_reg_d;
            dav_hist_q   <= dav_hist_d;
            rda_q        <= rda_d;
            char_we_q    <= char_we_d;
            char_out_q   <= char_out_d;
            wr_col_q     <= wr_col_d;
            wr_row_q     <= wr_row_d;
            scroll_req_q <= scroll_req_d;
        end
    end

    assign rda        = rda_q;
    assign char_we    = char_we_q;
    assign char_out   = char_out_q;
    assign wr_col     = wr_col_q;
    assign wr_row     = wr_row_q;
    assign scroll_req = scroll_req_q;

endmodule

// File: tb/tb_term_char_writer.sv
// tb_term_char_writer: directed test of the terminal character writer.
// A table of characters with hand-computed write results and latencies is
// replayed first, followed by hand-written sequences for wrap, newline,
// scroll, clear, lost triggers and mid-operation reset.
module tb_term_char_writer;

    logic       clk;
    logic       reset_n;
    logic       dav;
    logic [6:0] data;
    logic       clr;
    logic       scroll_ack;
    logic       rda;
    logic       char_we;
    logic [5:0] char_out;
    logic [5:0] wr_col;
    logic [4:0] wr_row;
    logic       scroll_req;

    int testsRun = 0;
    int testsFailed = 0;

    int         weCount;
    int         lat;
    logic [5:0] capChar;
    logic [5:0] capCol;
    logic [4:0] capRow;

    typedef struct {
        logic [6:0] data;
        int         expWe;
        int         expChar;
        int         expCol;
        int         expRow;
        int         expLat;
    } vec_t;

    vec_t vecs[10];

    term_char_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dav        (dav),
        .data       (data),
        .clr        (clr),
        .scroll_ack (scroll_ack),
        .rda        (rda),
        .char_we    (char_we),
        .char_out   (char_out),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .scroll_req (scroll_req)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Send one character with dav held through the whole operation, record
    // any write strobes and the number of edges until rda returns.
    task automatic applyStimulus(input logic [6:0] d);
        weCount = 0;
        lat     = -1;
        data    = d;
        dav     = 1'b1;
        tick();
        checkOutput("rda_low_after_trigger", int'(rda), 0);
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (char_we) begin
                weCount++;
                capChar = char_out;
                capCol  = wr_col;
                capRow  = wr_row;
            end
            if (rda) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) checkOutput("rda_timeout", int'(rda), 1);
        dav = 1'b0;
        tick();
    endtask

    task automatic sendMany(input int n, input logic [6:0] d);
        for (int i = 0; i < n; i++) applyStimulus(d);
    endtask

    task automatic pulseClr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Send a CR from row 23 and stop once scroll_req has been raised.
    task automatic enterScroll();
        data = 7'h0D;
        dav  = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("enter_scroll_req", int'(scroll_req), 1);
    endtask

    // Expect a single write at the given cursor position.
    task automatic expectWriteAt(input string name, input int col, input int row);
        checkOutput({name, "_we"}, weCount, 1);
        checkOutput({name, "_col"}, int'(capCol), col);
        checkOutput({name, "_row"}, int'(capRow), row);
    endtask

    // Main directed sequence.
    initial begin
        int reqLowSeen;
        int rdaHighSeen;
        int stray;

        vecs[0] = '{7'h41, 1, 6'h01, 0, 0, 3};
        vecs[1] = '{7'h07, 0, 0,     0, 0, 2};
        vecs[2] = '{7'h61, 0, 0,     0, 0, 2};
        vecs[3] = '{7'h5A, 1, 6'h1A, 1, 0, 3};
        vecs[4] = '{7'h0D, 0, 0,     0, 0, 3};
        vecs[5] = '{7'h20, 1, 6'h20, 0, 1, 3};
        vecs[6] = '{7'h5F, 1, 6'h1F, 1, 1, 3};
        vecs[7] = '{7'h1F, 0, 0,     0, 0, 2};
        vecs[8] = '{7'h60, 0, 0,     0, 0, 2};
        vecs[9] = '{7'h30, 1, 6'h30, 2, 1, 3};

        reset_n    = 1'b0;
        dav        = 1'b1;
        data       = 7'h41;
        clr        = 1'b0;
        scroll_ack = 1'b0;
        tick();
        tick();
        checkOutput("reset_rda", int'(rda), 1);
        checkOutput("reset_char_we", int'(char_we), 0);
        checkOutput("reset_scroll_req", int'(scroll_req), 0);
        checkOutput("reset_char_out", int'(char_out), 0);
        checkOutput("reset_wr_col", int'(wr_col), 0);
        checkOutput("reset_wr_row", int'(wr_row), 0);

        reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (char_we || !rda) stray++;
        end
        checkOutput("dav_high_at_release_ignored", stray, 0);
        dav = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].data);
            checkOutput($sformatf("vec%0d_we", v), weCount, vecs[v].expWe);
            checkOutput($sformatf("vec%0d_lat", v), lat, vecs[v].expLat);
            if (vecs[v].expWe != 0) begin
                checkOutput($sformatf("vec%0d_char", v), int'(capChar), vecs[v].expChar);
                checkOutput($sformatf("vec%0d_col", v), int'(capCol), vecs[v].expCol);
                checkOutput($sformatf("vec%0d_row", v), int'(capRow), vecs[v].expRow);
            end
        end

        // Full line of 40 characters, auto-wrap to the next row.
        pulseClr();
        checkOutput("clr_idle_rda", int'(rda), 1);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(7'h41);
            expectWriteAt($sformatf("line_%0d", i), i, 0);
            if (i == 39) checkOutput("wrap_lat", lat, 4);
        end
        applyStimulus(7'h42);
        expectWriteAt("after_wrap", 0, 1);

        // CR at col 17, row 5.
        pulseClr();
        sendMany(5, 7'h0D);
        sendMany(17, 7'h41);
        applyStimulus(7'h0D);
        checkOutput("cr_we", weCount, 0);
        checkOutput("cr_lat", lat, 3);
        applyStimulus(7'h41);
        expectWriteAt("after_cr", 0, 6);

        // Scroll with a delayed acknowledge.
        pulseClr();
        sendMany(23, 7'h0D);
        applyStimulus(7'h41);
        expectWriteAt("last_row", 0, 23);
        enterScroll();
        reqLowSeen  = 0;
        rdaHighSeen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!scroll_req) reqLowSeen++;
            if (rda) rdaHighSeen++;
        end
        checkOutput("scroll_req_held", reqLowSeen, 0);
        checkOutput("scroll_rda_low", rdaHighSeen, 0);
        scroll_ack = 1'b1;
        tick();
        scroll_ack = 1'b0;
        checkOutput("scroll_req_dropped", int'(scroll_req), 0);
        checkOutput("scroll_rda_not_yet", int'(rda), 0);
        tick();
        checkOutput("scroll_rda_back", int'(rda), 1);
        dav = 1'b0;
        tick();
        applyStimulus(7'h41);
        expectWriteAt("after_scroll", 0, 23);

        // clr while waiting in SCROLL.
        enterScroll();
        tick();
        pulseClr();
        checkOutput("clr_scroll_req", int'(scroll_req), 0);
        checkOutput("clr_scroll_rda", int'(rda), 1);
        checkOutput("clr_scroll_we", int'(char_we), 0);
        dav = 1'b0;
        tick();
        applyStimulus(7'h41);
        expectWriteAt("after_clr_scroll", 0, 0);

        // Trigger coincident with clr is dropped.
        clr  = 1'b1;
        data = 7'h41;
        dav  = 1'b1;
        tick();
        clr = 1'b0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (char_we || !rda) stray++;
        end
        checkOutput("clr_trigger_dropped", stray, 0);
        dav = 1'b0;
        tick();
        applyStimulus(7'h41);
        expectWriteAt("after_clr_trigger", 0, 0);

        // Second dav edge while busy is lost; dav left high gives one char.
        data  = 7'h42;
        dav   = 1'b1;
        stray = 0;
        tick();
        dav = 1'b0;
        tick();
        if (char_we) stray++;
        dav = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (char_we) stray++;
        end
        checkOutput("busy_trigger_lost", stray, 1);
        dav = 1'b0;
        tick();
        applyStimulus(7'h41);
        expectWriteAt("after_lost", 2, 0);

        // Asynchronous reset in the middle of a scroll.
        sendMany(23, 7'h0D);
        enterScroll();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_scroll_req", int'(scroll_req), 0);
        checkOutput("midreset_rda", int'(rda), 1);
        checkOutput("midreset_char_we", int'(char_we), 0);
        tick();
        reset_n = 1'b1;
        dav     = 1'b0;
        tick();
        applyStimulus(7'h41);
        expectWriteAt("after_midreset", 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
